mmu_pmpout_router: RTL

MMU_PMPOUT_ROUTER -- requirements
Module: mmu_pmpout_router

---
 rtl/mmu_pmpout_router.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mmu_pmpout_router.sv
// PMP result buffer: a small in-order FIFO whose head entry is routed to the dcache, retire or exception channel.
// Define MMU_PMPOUT_CNT_EN to add saturating per-channel pop counters.
module mmu_pmpout_router #(
    parameter int DEPTH   = 2,
    parameter int WAY_W   = 4,
    parameter int IDX_W   = 6,
    parameter int PADDR_W = 34
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 i_flush_1,
    input  logic                                 i_pmp_valid_1,
    output logic                                 o_pmp_ready_1,
    input  logic [WAY_W+IDX_W+5+2+PADDR_W-1:0]   i_pmp_data,
    output logic                                 o_dcache_valid_1,
    input  logic                                 i_dcache_ready_1,
    output logic [WAY_W+PADDR_W-1:0]             o_dcache_data,
    output logic                                 o_retire_valid_1,
    input  logic                                 i_retire_ready_1,
    output logic [IDX_W+5-1:0]                   o_retire_data,
    output logic                                 o_exp_valid_1,
    input  logic                                 i_exp_ready_1,
`ifdef MMU_PMPOUT_CNT_EN
    output logic [15:0]                          o_cnt_dcache_16,
    output logic [15:0]                          o_cnt_retire_16,
    output logic [15:0]                          o_cnt_exp_16,
`endif
    output logic [4:0]                           o_exp_data
);

    localparam int IN_W  = WAY_W + IDX_W + 5 + 2 + PADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Field positions inside a stored entry, LSB upwards
    localparam int ITYPE_LO = PADDR_W;
    localparam int MC_LO    = PADDR_W + 2;
    localparam int IDX_LO   = PADDR_W + 7;
    localparam int WAY_LO   = PADDR_W + 7 + IDX_W;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DC   = 2'd1,
        SEL_RT   = 2'd2,
        SEL_EX   = 2'd3
    } sel_e;

    logic [IN_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [IN_W-1:0]    w_head;
    logic [4:0]         w_mcause;
    logic               w_itype_hi;
    logic               w_unused_itype0;
    sel_e               w_sel;
    logic               w_push;
    logic               w_pop;

    assign w_head          = r_mem[r_rd_ptr];
    assign w_mcause        = w_head[MC_LO +: 5];
    assign w_itype_hi      = w_head[ITYPE_LO + 1];
    assign w_unused_itype0 = w_head[ITYPE_LO];

    // A full buffer refuses input even when the head pops this cycle
    assign o_pmp_ready_1 = (r_count < CNT_W'(DEPTH));
    assign w_push        = i_pmp_valid_1 & o_pmp_ready_1;

    // Select the destination channel of the head entry
    always_comb begin
        w_sel = SEL_NONE;
        if (r_count == CNT_W'(0)) begin
            w_sel = SEL_NONE;
        end else if (w_mcause == 5'd0) begin
            w_sel = SEL_DC;
        end else if (w_itype_hi) begin
            w_sel = SEL_RT;
        end else begin
            w_sel = SEL_EX;
        end
    end

    // Pop only on a handshake of the selected channel
    always_comb begin
        w_pop = 1'b0;
        case (w_sel)
            SEL_DC:  w_pop = i_dcache_ready_1;
            SEL_RT:  w_pop = i_retire_ready_1;
            SEL_EX:  w_pop = i_exp_ready_1;
            default: w_pop = 1'b0;
        endcase
    end

    assign o_dcache_valid_1 = (w_sel == SEL_DC);
    assign o_retire_valid_1 = (w_sel == SEL_RT);
    assign o_exp_valid_1    = (w_sel == SEL_EX);

    assign o_dcache_data = {w_head[WAY_LO +: WAY_W], w_head[PADDR_W-1:0]};
    assign o_retire_data = {w_head[IDX_LO +: IDX_W], w_mcause};
    assign o_exp_data    = w_mcause;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush_1) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_pmp_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef MMU_PMPOUT_CNT_EN
    logic [15:0] r_cnt_dcache;
    logic [15:0] r_cnt_retire;
    logic [15:0] r_cnt_exp;

    // Saturating pop counters; a pop discarded by flush is not counted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_dcache <= 16'd0;
            r_cnt_retire <= 16'd0;
            r_cnt_exp    <= 16'd0;
        end else if (w_pop && !i_flush_1) begin
            case (w_sel)
                SEL_DC:  r_cnt_dcache <= (r_cnt_dcache == 16'hFFFF) ? r_cnt_dcache : r_cnt_dcache + 16'd1;
                SEL_RT:  r_cnt_retire <= (r_cnt_retire == 16'hFFFF) ? r_cnt_retire : r_cnt_retire + 16'd1;
                SEL_EX:  r_cnt_exp    <= (r_cnt_exp    == 16'hFFFF) ? r_cnt_exp    : r_cnt_exp    + 16'd1;
                default: r_cnt_dcache <= r_cnt_dcache;
            endcase
        end else begin
            r_cnt_dcache <= r_cnt_dcache;
        end
    end

    assign o_cnt_dcache_16 = r_cnt_dcache;
    assign o_cnt_retire_16 = r_cnt_retire;
    assign o_cnt_exp_16    = r_cnt_exp;
`endif

endmodule
